// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle main control unit: FSM states, opcodes
// and the select/op codes driven onto the datapath.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mcu_multicycle_if.sv
// Control bundle between the main control unit (master) and the shared-memory
// multicycle datapath (slave): opcode and memory handshake in, strobes out.
interface mcu_multicycle_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] op;
  logic            mem_ready;
  logic            PCWrite;
  logic            Branch;
  logic            BranchNe;
  logic            IorD;
  logic            MemRd;
  logic            MemWr;
  logic            IRWrite;
  logic [1:0]      MemtoReg;
  logic [1:0]      RegDst;
  logic            RegWr;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic            ExtOp;
  logic [2:0]      ALUOp;
  logic [1:0]      PCSrc;
  logic            illegal;
  logic            mem_err;
  logic [3:0]      state;

  modport master (
    input  op, mem_ready,
    output PCWrite, Branch, BranchNe, IorD, MemRd, MemWr, IRWrite, MemtoReg,
           RegDst, RegWr, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, illegal,
           mem_err, state
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, Branch, BranchNe, IorD, MemRd, MemWr, IRWrite, MemtoReg,
           RegDst, RegWr, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSrc, illegal,
           mem_err, state
  );
endinterface

// File: rtl/mcu_mem_timer.sv
// Memory wait watchdog: counts stalled cycles in a memory step and flags expire
// combinationally on the last allowed one; TIMEOUT=0 never expires.
module mcu_mem_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = (TIMEOUT > 0) && waiting && !mem_ready && (cnt_q == LAST);

  // Non-waiting states keep the count at zero, so any state change starts fresh.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!waiting || mem_ready || expire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mcu_multicycle.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing
// with Mealy-gated fetch strobes and timeout-guarded memory stalls.
module mcu_multicycle
  import mcu_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mcu_multicycle_if.master bus
);
  state_t     state_q, state_d;
  logic       waiting, expire;
  logic [5:0] opc;

  assign opc     = 6'(bus.op);
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign bus.state = state_q;

  mcu_mem_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .mem_ready (bus.mem_ready),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.PCWrite  = 1'b0;
    bus.Branch   = 1'b0;
    bus.BranchNe = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRd    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemtoReg = M2R_ALU;
    bus.RegDst   = REGDST_RT;
    bus.RegWr    = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_B;
    bus.ExtOp    = 1'b0;
    bus.ALUOp    = ALU_ADD;
    bus.PCSrc    = PCSRC_ALU;
    bus.illegal  = 1'b0;
    bus.mem_err  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          bus.MemRd   = 1'b1;
          bus.ALUSrcB = SRCB_4;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
          bus.mem_err = expire;
          if (bus.mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          bus.ALUSrcB = SRCB_IMMSH;
          bus.ExtOp   = 1'b1;
          case (opc)
            OP_LW, OP_SW:                        state_d = S_MEMADR;
            OP_R:                                state_d = S_REXEC;
            OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_IMMEX;
            OP_J:                                state_d = S_JUMP;
            OP_JAL:                              state_d = S_JAL;
            default:                             state_d = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          bus.ExtOp   = 1'b1;
          state_d     = (opc == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          bus.MemRd   = 1'b1;
          bus.IorD    = 1'b1;
          bus.mem_err = expire;
          if (bus.mem_ready)  state_d = S_MEMWB;
          else if (expire)    state_d = S_FETCH;
        end
        S_MEMWB: begin
          bus.RegWr    = 1'b1;
          bus.MemtoReg = M2R_MDR;
          state_d      = S_FETCH;
        end
        S_MEMWR: begin
          bus.MemWr   = 1'b1;
          bus.IorD    = 1'b1;
          bus.mem_err = expire;
          if (bus.mem_ready || expire) state_d = S_FETCH;
        end
        S_REXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALU_FUNCT;
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          bus.RegWr  = 1'b1;
          bus.RegDst = REGDST_RD;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUOp    = ALU_SUB;
          bus.PCSrc    = PCSRC_ALUOUT;
          bus.Branch   = (opc == OP_BEQ);
          bus.BranchNe = (opc == OP_BNE);
          state_d      = S_FETCH;
        end
        S_IMMEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
          case (opc)
            OP_ANDI: bus.ALUOp = ALU_AND;
            OP_ORI:  bus.ALUOp = ALU_OR;
            OP_SLTI: begin bus.ALUOp = ALU_SLT; bus.ExtOp = 1'b1; end
            default: begin bus.ALUOp = ALU_ADD; bus.ExtOp = 1'b1; end
          endcase
          state_d = S_IMMWB;
        end
        S_IMMWB: begin
          bus.RegWr = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = PCSRC_JUMP;
          state_d     = S_FETCH;
        end
        // PC already holds PC+4 from fetch, which is the link value.
        S_JAL: begin
          bus.PCWrite  = 1'b1;
          bus.PCSrc    = PCSRC_JUMP;
          bus.RegWr    = 1'b1;
          bus.RegDst   = REGDST_R31;
          bus.MemtoReg = M2R_PC;
          state_d      = S_FETCH;
        end
        S_ILLEGAL: begin
          bus.illegal = 1'b1;
          state_d     = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: doc/mcu_multicycle.md
Name: mcu_multicycle

Overview:
Multicycle successor to the single-cycle main control unit. A registered FSM sequences each instruction through fetch, decode, execute, memory and writeback. It supports R-type, lw, sw, beq, bne, j, jal, addi, andi, ori and slti, and flags illegal opcodes. Memory steps stall on a ready handshake, guarded by a timeout counter. It drives the shared-memory multicycle datapath: PC, IR, A/B and ALUOut registers.

Parameters:
OP_W, 6, opcode width
TIMEOUT, 15, max wait cycles for mem_ready per memory step; 0 disables timeout
CNT_W, 4, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset
op  in  OP_W  opcode from IR
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if ALU zero (beq)
BranchNe  out  1  PC load if ALU not zero (bne)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRd  out  1  memory read request
MemWr  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC (link)
RegDst  out  2  write reg: 00 rt, 01 rd, 10 r31
RegWr  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
ExtOp  out  1  1=sign-extend, 0=zero-extend
ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump target
illegal  out  1  one-cycle pulse on unsupported opcode
mem_err  out  1  one-cycle pulse on timeout
state  out  4  current state, for debug

Behaviour:
- Synchronous, active-high rst: state<=FETCH and counter<=0. While rst=1, all outputs are 0 except state. Outputs not listed for a state are 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, JAL, ILLEGAL. Encoding lives in the package.
- FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00. IRWrite and PCWrite equal mem_ready (Mealy-gated). Stay while mem_ready=0; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=add (precomputes branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> REXEC
  - 000100 or 000101 -> BRANCH
  - 001000, 001100, 001101 or 001010 -> IMMEX
  - 000010 -> JUMP
  - 000011 -> JAL
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRd=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegWr=1, RegDst=00, MemtoReg=01. Then FETCH.
- MEMWR: MemWr=1, IorD=1. Wait for mem_ready, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Then ALUWB.
- ALUWB: RegWr=1, RegDst=01, MemtoReg=00. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01. Branch=1 for beq, BranchNe=1 for bne. Then FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. addi: ExtOp=1, ALUOp=add. andi: ExtOp=0, ALUOp=and. ori: ExtOp=0, ALUOp=or. slti: ExtOp=1, ALUOp=slt. Then IMMWB.
- IMMWB: RegWr=1, RegDst=00, MemtoReg=00. Then FETCH.
- JUMP: PCWrite=1, PCSrc=10. Then FETCH.
- JAL: PCWrite=1, PCSrc=10, RegWr=1, RegDst=10, MemtoReg=10. The PC in this state is already PC+4. Then FETCH.
- ILLEGAL: illegal=1 for one cycle, no writes. Then FETCH; PC was already advanced.
- Timeout counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0. Clears on every state change and on mem_ready.
  - If TIMEOUT>0 and count==TIMEOUT-1 with mem_ready=0, that cycle: mem_err=1, counter<=0, next state FETCH. The aborted access writes nothing.
  - A FETCH timeout restarts the fetch.
  - mem_ready=1 in the timeout cycle wins: normal completion, no mem_err.
- op is sampled in DECODE, MEMADR, BRANCH and IMMEX. IR is stable outside FETCH.
- rst asserted mid-instruction aborts it: no further writes, FETCH on the next cycle.

Decomposition:
- Package mcu_pkg holds:
  - state localparams
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - ALUOp, ALUSrcB, PCSrc, RegDst and MemtoReg encodings
- Sub-module mcu_mem_timer: the wait counter, with inputs waiting and mem_ready, output expire.
- Next-state logic and output decode stay in mcu_multicycle.

Test Plan:
- Reset, with rst held 2 cycles then released -> state=FETCH, MemRd=1; all other strobes 0 during rst.
- R-type, op=000000, mem_ready tied 1 -> FETCH, DECODE, REXEC, ALUWB: 4 cycles. ALUOp=010 in REXEC; RegWr=1 and RegDst=01 in ALUWB.
- lw, op=100011, mem_ready low 2 cycles in MEMRD -> 7 cycles total. IRWrite pulses exactly once; MemtoReg=01 and RegWr=1 in MEMWB.
- bne, op=000101 -> BranchNe=1, Branch=0, PCSrc=01, ALUOp=001 in BRANCH. beq gives Branch=1, BranchNe=0.
- jal, op=000011 -> in JAL: RegDst=10, MemtoReg=10, PCWrite=1, PCSrc=10. ori gives ExtOp=0, ALUOp=100.
- Errors:
  - op=111111 -> illegal pulses 1 cycle, then FETCH with no RegWr or MemWr.
  - sw with mem_ready=0 for 15 cycles -> mem_err on the 15th cycle, then FETCH.
  - Same case with TIMEOUT=0 -> waits indefinitely.
